// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the sequential binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_e;

    localparam int          BCD_DIGITS = 3;
    localparam int          NIBBLE_W   = 4;
    localparam int          BCD_W      = BCD_DIGITS * NIBBLE_W;
    localparam logic [7:0]  BCD_MAX    = 8'h99;

    // Double-dabble correction threshold: a digit of 5..9 overflows on the next shift.
    function automatic logic nibble_needs_add3(input logic [NIBBLE_W-1:0] nib);
        return (nib >= NIBBLE_W'(5));
    endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module   : bcd_add3
// Brief    : Combinational double-dabble digit correction (>=5 gets +3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nib,
    output logic [NIBBLE_W-1:0] o_nib
);

    // 4-bit wrap is intentional; the carry into the next digit arrives via the shift.
    assign o_nib = nibble_needs_add3(i_nib) ? (i_nib + NIBBLE_W'(3)) : i_nib;

endmodule : bcd_add3

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Iterative (one bit per cycle) binary to 2-digit packed BCD with
//            valid/ready input and held output for a 7-segment driver.
//            Optional macro BCD_SATURATE_EN: values >99 display as 8'h99.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    output logic [7:0]       out_bcd,
    output logic             out_valid,
    output logic             ovf
);

    localparam int              c_CNT_W   = $clog2(BIN_W + 1);
    localparam int              c_SR_W    = BCD_W + BIN_W;
    localparam logic [0:0]      c_ST_IDLE  = IDLE;
    localparam logic [0:0]      c_ST_SHIFT = SHIFT;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    logic [0:0]         r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [c_SR_W-1:0]  r_sr_q,    w_sr_d;
    logic [7:0]         r_bcd_q,   w_bcd_d;
    logic               r_ovf_q,   w_ovf_d;
    logic               r_valid_q, w_valid_d;

    logic [c_SR_W-1:0]  w_sr_corr;
    logic [c_SR_W-1:0]  w_sr_shift;
    logic [BCD_W-1:0]   w_res;
    logic               w_hund_nz;
    logic [7:0]         w_bcd_sel;
    logic               w_last;

    assign w_sr_corr[BIN_W-1:0] = r_sr_q[BIN_W-1:0];

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
        bcd_add3 u_add3 (
            .i_nib (r_sr_q   [BIN_W + gi*NIBBLE_W +: NIBBLE_W]),
            .o_nib (w_sr_corr[BIN_W + gi*NIBBLE_W +: NIBBLE_W])
        );
    end

    assign w_sr_shift = w_sr_corr << 1;
    assign w_res      = w_sr_shift[BIN_W +: BCD_W];
    assign w_hund_nz  = |w_res[BCD_W-1:2*NIBBLE_W];
    assign w_last     = (r_cnt_q == c_LAST);

`ifdef BCD_SATURATE_EN
    assign w_bcd_sel = w_hund_nz ? BCD_MAX : w_res[7:0];
`else
    assign w_bcd_sel = w_res[7:0];
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_sr_d    = r_sr_q;
        w_bcd_d   = r_bcd_q;
        w_ovf_d   = r_ovf_q;
        w_valid_d = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_sr_d    = {{BCD_W{1'b0}}, in_bin};
                    w_cnt_d   = '0;
                    w_state_d = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                w_sr_d  = w_sr_shift;
                w_cnt_d = r_cnt_q + c_CNT_W'(1);
                // Result only becomes visible on the final iteration edge.
                if (w_last) begin
                    w_bcd_d   = w_bcd_sel;
                    w_ovf_d   = w_hund_nz;
                    w_valid_d = 1'b1;
                    w_state_d = c_ST_IDLE;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
            r_cnt_q   <= '0;
            r_sr_q    <= '0;
            r_bcd_q   <= 8'h00;
            r_ovf_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_sr_q    <= w_sr_d;
            r_bcd_q   <= w_bcd_d;
            r_ovf_q   <= w_ovf_d;
            r_valid_q <= w_valid_d;
        end
    end

    // Ready is masked while reset is held so nothing is accepted during reset.
    assign in_ready  = (r_state_q == c_ST_IDLE) && !rst;
    assign out_bcd   = r_bcd_q;
    assign ovf       = r_ovf_q;
    assign out_valid = r_valid_q;

endmodule : bin_to_bcd_seq

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Scoreboard bench for bin_to_bcd_seq (honours BCD_SATURATE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BIN_W-1:0] in_bin = '0;
    logic [7:0]       out_bcd;
    logic             out_valid;
    logic             ovf;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         ready_at = 0;
    logic [7:0] held_bcd = 8'h00;
    logic       held_ovf = 1'b0;
    bit         started  = 1'b0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits of the value, hundreds dropped or saturated.
    function automatic exp_t model(input int v, input int due);
        exp_t e;
        int   low;
        low   = v % 100;
        e.ovf = (v > 99);
        e.bcd = {4'(low / 10), 4'(low % 10)};
`ifdef BCD_SATURATE_EN
        if (v > 99) e.bcd = 8'h99;
`endif
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", int'(in_ready), int'(!rst && (cyc >= ready_at)));
            if (out_valid) begin
                chk("out_valid_gap", int'(prev_valid), 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got out_bcd=%0h with nothing pending at cycle %0d",
                             out_bcd, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_bcd", int'(out_bcd), int'(e.bcd));
                    chk("ovf", int'(ovf), int'(e.ovf));
                    chk("latency", cyc, e.due);
                    held_bcd = e.bcd;
                    held_ovf = e.ovf;
                end
            end else begin
                chk("out_bcd_hold", int'(out_bcd), int'(held_bcd));
                chk("ovf_hold", int'(ovf), int'(held_ovf));
            end
            prev_valid = out_valid;
        end
    end

    // Present v, wait for the handshake, record the expectation; in_valid stays high.
    task automatic offer(input int v, output int acc);
        bit found;
        in_valid = 1'b1;
        in_bin   = BIN_W'(v);
        found    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: value %0d never accepted (in_ready=%0d)", v, in_ready);
            acc = -1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        ready_at = cyc + BIN_W;
        sb.push_back(model(v, cyc + BIN_W));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, a7, a8, v;
        @(posedge clk);
        #1;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        offer(42, a);
        in_valid = 1'b0;
        drain();

        offer(99, a);
        offer(100, a);
        offer(255, a);
        in_valid = 1'b0;
        drain();

        offer(7, a7);
        offer(8, a8);
        in_valid = 1'b0;
        chk("chain_gap", a8 - a7, BIN_W + 1);
        drain();

        // Abort during the 4th SHIFT cycle.
        offer(123, a);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        sb.delete();
        held_bcd = 8'h00;
        held_ovf = 1'b0;
        ready_at = 0;
        repeat (BIN_W + 4) @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, (1 << BIN_W) - 1));
            offer(v, a);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq

`default_nettype wire
